// File: rtl/ft_to_fx.sv
// ft_to_fx: IEEE-754 binary32 to signed fixed-point converter (Q(OUT_W-FRAC_BITS).FRAC_BITS).
// Three registered stages (unpack, align, sign/saturate) under a single stall signal.
// Truncates toward zero. Saturates and flags out-of-range values and Inf. NaN gives 0 with a flag.
module ft_to_fx #(
    parameter int OUT_W     = 24,
    parameter int FRAC_BITS = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_nan
);

    // Right-shift amount that puts 2^0 of the 24-bit significand on bit FRAC_BITS
    localparam logic signed [9:0] SH_BIAS = 10'(150 - FRAC_BITS);
    localparam logic [63:0]       LIM_W   = 64'd1 << (OUT_W - 1);
    localparam logic [OUT_W-1:0]  MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]  ONE_W   = {{(OUT_W-1){1'b0}}, 1'b1};

    logic                    adv_s;
    logic [7:0]              e_s;
    logic [22:0]             m_s;
    logic signed [9:0]       sh_s;

    logic                    v1_r, s1_sign_r, s1_nan_r, s1_inf_r, s1_zero_r;
    logic [23:0]             s1_sig_r;
    logic signed [9:0]       s1_sh_r;

    logic signed [9:0]       neg_sh_s;
    logic [63:0]             mag_wide_s;
    logic                    big_s;

    logic                    v2_r, s2_sign_r, s2_nan_r, s2_inf_r, s2_zero_r, s2_ovf_r, s2_exact_r;
    logic [OUT_W-1:0]        s2_mag_r;

    logic [OUT_W-1:0]        data_s;
    logic                    ovf_s, nan_s;

    logic                    out_valid_r, out_ovf_r, out_nan_r;
    logic [OUT_W-1:0]        out_data_r;

    // The whole pipe advances whenever the output slot is empty or being drained
    assign adv_s    = !out_valid_r | out_ready;
    assign in_ready = adv_s;

    assign e_s  = in_data[30:23];
    assign m_s  = in_data[22:0];
    assign sh_s = SH_BIAS - $signed({2'b00, e_s});

    // Stage 1: unpack fields and classify the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r      <= 1'b0;
            s1_sign_r <= 1'b0;
            s1_nan_r  <= 1'b0;
            s1_inf_r  <= 1'b0;
            s1_zero_r <= 1'b0;
            s1_sig_r  <= 24'd0;
            s1_sh_r   <= 10'sd0;
        end else if (adv_s) begin
            v1_r      <= in_valid;
            s1_sign_r <= in_data[31];
            s1_nan_r  <= (e_s == 8'hFF) && (m_s != 23'd0);
            s1_inf_r  <= (e_s == 8'hFF) && (m_s == 23'd0);
            s1_zero_r <= (e_s == 8'h00);
            s1_sig_r  <= {(e_s != 8'h00), m_s};
            s1_sh_r   <= sh_s;
        end
    end

    assign neg_sh_s = 10'sd0 - s1_sh_r;

    // Stage 2 combinational: align significand; huge left shifts are marked as out of range
    always_comb begin
        mag_wide_s = 64'd0;
        big_s      = 1'b0;
        if (s1_zero_r) begin
            mag_wide_s = 64'd0;
        end else if (s1_sh_r >= 10'sd24) begin
            mag_wide_s = 64'd0;
        end else if (s1_sh_r >= 10'sd0) begin
            mag_wide_s = {40'd0, s1_sig_r} >> s1_sh_r[4:0];
        end else if (neg_sh_s > 10'sd32) begin
            big_s = 1'b1;
        end else begin
            mag_wide_s = {40'd0, s1_sig_r} << neg_sh_s[5:0];
        end
    end

    // Stage 2: register aligned magnitude and range classification
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r       <= 1'b0;
            s2_sign_r  <= 1'b0;
            s2_nan_r   <= 1'b0;
            s2_inf_r   <= 1'b0;
            s2_zero_r  <= 1'b0;
            s2_ovf_r   <= 1'b0;
            s2_exact_r <= 1'b0;
            s2_mag_r   <= {OUT_W{1'b0}};
        end else if (adv_s) begin
            v2_r       <= v1_r;
            s2_sign_r  <= s1_sign_r;
            s2_nan_r   <= s1_nan_r;
            s2_inf_r   <= s1_inf_r;
            s2_zero_r  <= !big_s && (mag_wide_s == 64'd0);
            s2_ovf_r   <= !s1_nan_r && (s1_inf_r || big_s || (mag_wide_s >= LIM_W));
            s2_exact_r <= !big_s && (mag_wide_s == LIM_W);
            s2_mag_r   <= mag_wide_s[OUT_W-1:0];
        end
    end

    // Stage 3 combinational: apply sign and saturation; -2^(OUT_W-1) exactly is representable
    always_comb begin
        data_s = {OUT_W{1'b0}};
        ovf_s  = 1'b0;
        nan_s  = 1'b0;
        if (s2_nan_r) begin
            nan_s = 1'b1;
        end else if (s2_zero_r) begin
            data_s = {OUT_W{1'b0}};
        end else if (s2_ovf_r) begin
            if (!s2_sign_r) begin
                data_s = MAX_POS;
                ovf_s  = 1'b1;
            end else begin
                data_s = MIN_NEG;
                ovf_s  = !(s2_exact_r && !s2_inf_r);
            end
        end else begin
            data_s = s2_sign_r ? (~s2_mag_r + ONE_W) : s2_mag_r;
        end
    end

    // Stage 3: output registers, held stable while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            out_ovf_r   <= 1'b0;
            out_nan_r   <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= v2_r;
            out_data_r  <= data_s;
            out_ovf_r   <= ovf_s;
            out_nan_r   <= nan_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ovf   = out_ovf_r;
    assign out_nan   = out_nan_r;

endmodule
